// File: rtl/comp1_bus_regfile_slave_if.sv
// comp1 valid/ready read/write bus.
//   master drives: valid, write, addr, data_wr, strb
//   slave drives : ready, data_rd, err
interface comp1_bus_regfile_slave_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) ();
   logic                  valid;
   logic                  write;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     data_wr;
   logic [DATA_W/8-1:0]   strb;
   logic                  ready;
   logic [DATA_W-1:0]     data_rd;
   logic                  err;

   modport master (
      output valid, write, addr, data_wr, strb,
      input  ready, data_rd, err
   );

   modport slave (
      input  valid, write, addr, data_wr, strb,
      output ready, data_rd, err
   );
endinterface

// File: rtl/comp1_bus_regfile_slave.sv
// Register-file responder on the comp1 bus with programmable wait states,
// byte-strobed writes, error responses, a sticky protocol-violation flag and
// a wrapping completed-transfer counter.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         asynchronous active-high reset
//   bus         comp1 bus, slave side (valid/write/addr/data_wr/strb in,
//               ready/data_rd/err out)
//   wait_cfg_i  wait states inserted before ready, sampled in IDLE only
//   proto_err_o sticky protocol-violation flag
//   xfer_cnt_o  completed transfers, wraps
//
// state | meaning
// IDLE  | no transfer; valid=1 starts one and loads wait_cfg_i
// WAIT  | counting wait states; leaves for RESP when the counter is 1
// RESP  | ready=1 for one cycle; completion edge commits write and count
module comp1_bus_regfile_slave #(
   parameter int          DATA_W   = 32,
   parameter int          ADDR_W   = 8,
   parameter int          NUM_REGS = 16,
   parameter logic [31:0] ID_VALUE = 32'hC0A1_0001,
   parameter int          WAIT_W   = 4,
   parameter int          CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   comp1_bus_regfile_slave_if.slave bus,
   input  logic [WAIT_W-1:0]        wait_cfg_i,
   output logic                     proto_err_o,
   output logic [CNT_W-1:0]         xfer_cnt_o
);

   localparam int                STRB_W  = DATA_W / 8;
   localparam logic [DATA_W-1:0] ID_WORD = DATA_W'(ID_VALUE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;
   logic                ready_q, ready_d;
   logic [DATA_W-1:0]   data_rd_q, data_rd_d;
   logic                err_q, err_d;
   logic                proto_err_q, proto_err_d;
   logic [CNT_W-1:0]    xfer_cnt_q, xfer_cnt_d;
   logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
   logic [DATA_W-1:0]   regs_d [1:NUM_REGS-1];

   logic                hit;
   logic [DATA_W-1:0]   rd_word;
   logic                commit;

   // Address decode by equality against each implemented index, so an
   // out-of-range address never indexes the array.
   always_comb begin
      hit     = 1'b0;
      rd_word = '0;
      if (bus.addr == '0) begin
         hit     = 1'b1;
         rd_word = ID_WORD;
      end
      for (int i = 1; i < NUM_REGS; i++) begin
         if (bus.addr == ADDR_W'(i)) begin
            hit     = 1'b1;
            rd_word = regs_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
         data_rd_q   <= '0;
         err_q       <= 1'b0;
         proto_err_q <= 1'b0;
         xfer_cnt_q  <= '0;
         for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         data_rd_q   <= data_rd_d;
         err_q       <= err_d;
         proto_err_q <= proto_err_d;
         xfer_cnt_q  <= xfer_cnt_d;
         regs_q      <= regs_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.valid) state_d = (wait_cfg_i == '0) ? ST_RESP : ST_WAIT;
         ST_WAIT: begin
            if (!bus.valid)       state_d = ST_IDLE;
            else if (cnt_q == 1)  state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      proto_err_d = proto_err_q;
      xfer_cnt_d  = xfer_cnt_q;
      commit      = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.valid) cnt_d = wait_cfg_i;
         ST_WAIT: begin
            if (bus.valid) cnt_d = cnt_q - 1'b1;
            else           proto_err_d = 1'b1;
         end
         ST_RESP: begin
            if (bus.valid) begin
               commit     = 1'b1;
               xfer_cnt_d = xfer_cnt_q + 1'b1;
            end else begin
               proto_err_d = 1'b1;
            end
         end
         default: ;
      endcase

      // Response fields are registered alongside ready so they appear together
      // and fall back to zero the cycle after RESP.
      ready_d   = (state_d == ST_RESP);
      data_rd_d = '0;
      err_d     = 1'b0;
      if (state_d == ST_RESP) begin
         err_d = !hit || (bus.write && bus.addr == '0);
         if (!bus.write && hit) data_rd_d = rd_word;
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (commit && bus.write) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (bus.addr == ADDR_W'(i)) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (bus.strb[b]) regs_d[i][8*b +: 8] = bus.data_wr[8*b +: 8];
               end
            end
         end
      end
   end

   assign bus.ready   = ready_q;
   assign bus.data_rd = data_rd_q;
   assign bus.err     = err_q;
   assign proto_err_o = proto_err_q;
   assign xfer_cnt_o  = xfer_cnt_q;

endmodule

// File: tb/tb_comp1_bus_regfile_slave.sv
module tb_comp1_bus_regfile_slave;
   localparam int          DATA_W   = 32;
   localparam int          ADDR_W   = 8;
   localparam int          NUM_REGS = 16;
   localparam int          WAIT_W   = 4;
   localparam int          CNT_W    = 4;
   localparam logic [31:0] ID_VALUE = 32'hC0A1_0001;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [WAIT_W-1:0] wait_cfg;
   logic              proto_err;
   logic [CNT_W-1:0]  xfer_cnt;

   comp1_bus_regfile_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   comp1_bus_regfile_slave #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
      .ID_VALUE(ID_VALUE), .WAIT_W(WAIT_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .wait_cfg_i(wait_cfg), .proto_err_o(proto_err), .xfer_cnt_o(xfer_cnt)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] mem [NUM_REGS];
   int          exp_cnt;
   bit          exp_proto;
   time         t_ready;

   task automatic model_reset();
      mem[0] = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) mem[i] = '0;
      exp_cnt   = 0;
      exp_proto = 0;
   endtask

   // One complete transfer starting #1 after a posedge; checks latency,
   // response fields, post-response idle values and counters.
   task automatic do_xfer(input bit wr, input int a, input logic [31:0] d,
                          input logic [3:0] s, input int w, input bit hold);
      logic [31:0] exp_rd;
      bit          exp_err;
      int          lat;
      if (a >= NUM_REGS) begin exp_err = 1; exp_rd = '0; end
      else if (wr)       begin exp_err = (a == 0); exp_rd = '0; end
      else               begin exp_err = 0; exp_rd = mem[a]; end

      bus.valid   = 1'b1;
      bus.write   = wr;
      bus.addr    = a[ADDR_W-1:0];
      bus.data_wr = d;
      bus.strb    = s;
      wait_cfg    = w[WAIT_W-1:0];
      @(posedge clk); #1;
      wait_cfg = 4'($urandom);
      lat = 0;
      while (bus.ready !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      t_ready = $time;
      n_checks++;
      if (lat !== w) $display("FAIL latency addr=%0d got %0d cycles want %0d", a, lat, w);
      else n_pass++;
      n_checks++;
      if (bus.data_rd !== exp_rd) $display("FAIL data_rd addr=%0d wr=%0d got %h want %h", a, wr, bus.data_rd, exp_rd);
      else n_pass++;
      n_checks++;
      if (bus.err !== exp_err) $display("FAIL err addr=%0d wr=%0d got %b want %b", a, wr, bus.err, exp_err);
      else n_pass++;

      @(posedge clk); #1;
      if (wr && a > 0 && a < NUM_REGS)
         for (int b = 0; b < 4; b++) if (s[b]) mem[a][8*b +: 8] = d[8*b +: 8];
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);

      n_checks++;
      if (bus.ready !== 1'b0) $display("FAIL ready_after got %b want 0", bus.ready);
      else n_pass++;
      n_checks++;
      if (bus.data_rd !== '0 || bus.err !== 1'b0)
         $display("FAIL resp_clear got data_rd=%h err=%b want 0/0", bus.data_rd, bus.err);
      else n_pass++;
      n_checks++;
      if (xfer_cnt !== exp_cnt[CNT_W-1:0]) $display("FAIL xfer_cnt got %0d want %0d", xfer_cnt, exp_cnt);
      else n_pass++;
      n_checks++;
      if (proto_err !== exp_proto) $display("FAIL proto_err got %b want %b", proto_err, exp_proto);
      else n_pass++;
      if (!hold) bus.valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      n_checks++;
      if (bus.ready !== 1'b0 || bus.data_rd !== '0 || bus.err !== 1'b0)
         $display("FAIL reset_resp got ready=%b data_rd=%h err=%b want 0", bus.ready, bus.data_rd, bus.err);
      else n_pass++;
      n_checks++;
      if (proto_err !== 1'b0 || xfer_cnt !== '0)
         $display("FAIL reset_flags got proto_err=%b xfer_cnt=%0d want 0/0", proto_err, xfer_cnt);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_id_read();
      do_xfer(0, 0, '0, '0, 0, 0);
   endtask

   task automatic test_strobe_write();
      do_xfer(1, 3, 32'hDEAD_BEEF, 4'b0101, 3, 0);
      do_xfer(0, 3, '0, '0, 0, 0);
      do_xfer(1, 3, 32'h1234_5678, 4'b0000, 1, 0);
      do_xfer(0, 3, '0, '0, 2, 0);
   endtask

   task automatic test_errors();
      int c0;
      c0 = exp_cnt;
      do_xfer(0, NUM_REGS, '0, '0, 0, 0);
      do_xfer(1, 0, 32'hFFFF_FFFF, 4'hF, 2, 0);
      n_checks++;
      if (xfer_cnt !== 4'((c0 + 2) % 16)) $display("FAIL err_count got %0d want %0d", xfer_cnt, (c0 + 2) % 16);
      else n_pass++;
      do_xfer(0, 0, '0, '0, 1, 0);
      do_xfer(0, 255, '0, '0, 0, 0);
   endtask

   task automatic test_back_to_back();
      time t_prev;
      int  c0;
      c0 = exp_cnt;
      t_prev = 0;
      for (int i = 0; i < 5; i++) begin
         do_xfer(0, $urandom_range(NUM_REGS - 1, 0), '0, '0, 0, 1);
         if (i > 0) begin
            n_checks++;
            if (t_ready - t_prev !== 20) $display("FAIL b2b_spacing got %0t want 20", t_ready - t_prev);
            else n_pass++;
         end
         t_prev = t_ready;
      end
      bus.valid = 1'b0;
      n_checks++;
      if (xfer_cnt !== 4'((c0 + 5) % 16)) $display("FAIL b2b_count got %0d want %0d", xfer_cnt, (c0 + 5) % 16);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         int a;
         a = ($urandom_range(4, 0) == 0) ? $urandom_range(255, NUM_REGS) : $urandom_range(NUM_REGS - 1, 0);
         do_xfer($urandom_range(1, 0) == 1, a, $urandom, 4'($urandom), $urandom_range(3, 0), 0);
      end
   endtask

   task automatic test_wrap();
      while (exp_cnt != 15) do_xfer(0, $urandom_range(NUM_REGS - 1, 0), '0, '0, 0, 0);
      n_checks++;
      if (xfer_cnt !== 4'd15) $display("FAIL wrap_pre got %0d want 15", xfer_cnt);
      else n_pass++;
      do_xfer(1, 7, $urandom, 4'hF, 1, 0);
      n_checks++;
      if (xfer_cnt !== 4'd0) $display("FAIL wrap got %0d want 0", xfer_cnt);
      else n_pass++;
   endtask

   task automatic test_proto_err();
      int seen;
      do_xfer(1, 5, 32'hA5A5_0F0F, 4'hF, 0, 0);
      bus.valid = 1'b1; bus.write = 1'b1; bus.addr = 8'd5;
      bus.data_wr = 32'h1111_2222; bus.strb = 4'hF; wait_cfg = 4'd5;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.valid = 1'b0;
      @(posedge clk); #1;
      exp_proto = 1;
      n_checks++;
      if (proto_err !== 1'b1) $display("FAIL proto_set got %b want 1", proto_err);
      else n_pass++;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.ready === 1'b1) seen++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (seen !== 0) $display("FAIL proto_no_ready got %0d pulses want 0", seen);
      else n_pass++;
      n_checks++;
      if (xfer_cnt !== exp_cnt[CNT_W-1:0]) $display("FAIL proto_count got %0d want %0d", xfer_cnt, exp_cnt);
      else n_pass++;
      do_xfer(0, 5, '0, '0, 2, 0);
   endtask

   task automatic test_async_reset();
      bus.valid = 1'b1; bus.write = 1'b0; bus.addr = 8'd1; wait_cfg = 4'd7;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (proto_err !== 1'b0 || xfer_cnt !== '0 || bus.ready !== 1'b0)
         $display("FAIL async_rst_wait got proto_err=%b xfer_cnt=%0d ready=%b want 0", proto_err, xfer_cnt, bus.ready);
      else n_pass++;
      bus.valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();

      do_xfer(0, 2, '0, '0, 0, 0);
      bus.valid = 1'b1; bus.write = 1'b0; bus.addr = 8'd0; wait_cfg = 4'd0;
      @(posedge clk); #1;
      n_checks++;
      if (bus.ready !== 1'b1 || bus.data_rd !== ID_VALUE)
         $display("FAIL pre_rst_resp got ready=%b data_rd=%h want 1/%h", bus.ready, bus.data_rd, ID_VALUE);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.ready !== 1'b0 || bus.data_rd !== '0 || bus.err !== 1'b0 || xfer_cnt !== '0)
         $display("FAIL async_rst_resp got ready=%b data_rd=%h err=%b xfer_cnt=%0d want 0", bus.ready, bus.data_rd, bus.err, xfer_cnt);
      else n_pass++;
      bus.valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      do_xfer(0, 3, '0, '0, 1, 0);
      do_xfer(0, 5, '0, '0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.valid = 1'b0; bus.write = 1'b0; bus.addr = '0;
      bus.data_wr = '0; bus.strb = '0; wait_cfg = '0;
      model_reset();
      test_reset();
      test_id_read();
      test_strobe_write();
      test_errors();
      test_back_to_back();
      test_random();
      test_wrap();
      test_proto_err();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
